// File: rtl/uart_pkg.sv
// Shared UART definitions: word width, handshake FSM encoding and tx-busy timeout default.
// Used by the receive, send and word-FIFO blocks.
package uart_pkg;

    localparam int DATA_W_DEF       = 64;
    localparam int BUSY_TIMEOUT_DEF = 1023;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_RISE = 2'd1,
        ST_WAIT_FALL = 2'd2
    } uart_state_e;

endpackage

// File: rtl/sync_fifo_mem.sv
// Single-clock FIFO storage: array, wrapping pointers and a separately tracked occupancy count.
// Head word is visible combinationally; push while full is accepted only alongside a pop.
module sync_fifo_mem #(
    parameter int  DATA_W = 64,
    parameter int  DEPTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int CNT_W  = ADDR_W + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] wr_dat_i,
    output logic [DATA_W-1:0] rd_dat_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_ok, pop_ok;

    assign full_o   = (count_q == FULL_CNT);
    assign empty_o  = (count_q == '0);
    assign push_ok  = push_i && (!full_o || pop_i);
    assign pop_ok   = pop_i && !empty_o;
    assign rd_dat_o = mem_q[rd_ptr_q];
    assign count_o  = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
        else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy gates every read.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_dat_i;
    end

endmodule

// File: rtl/uart_word_fifo.sv
// Elastic word buffer between UART receive and send; replays words via send_en/tx_busy handshake.
// Optional UART_FIFO_STATS_EN adds saturating drop_cnt and timeout_cnt outputs.
module uart_word_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int DEPTH        = 8,
    parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     recv_done,
    input  logic [DATA_W-1:0]        recv_data,
    input  logic                     tx_busy,
    output logic                     send_en,
    output logic [DATA_W-1:0]        send_data,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
`ifdef UART_FIFO_STATS_EN
    ,
    output logic [15:0]              drop_cnt,
    output logic [15:0]              timeout_cnt
`endif
);

    localparam int               TMR_W   = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(BUSY_TIMEOUT);

    uart_state_e       state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              send_en_q, send_en_d;
    logic [DATA_W-1:0] send_data_q, send_data_d;
    logic              overflow_q, overflow_d;
    logic [DATA_W-1:0] head_dat;
    logic              fifo_full, fifo_empty;
    logic              pop, drop, timeout_hit;

    // Pop decision uses registered occupancy only, so a fresh push waits one cycle.
    assign pop         = (state_q == ST_IDLE) && !fifo_empty && !tx_busy;
    assign drop        = recv_done && fifo_full && !pop;
    assign timeout_hit = (state_q == ST_WAIT_RISE) && !tx_busy && (timer_q == TMR_MAX);

    sync_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk_i    (sys_clk),
        .rst_i    (sys_rst),
        .push_i   (recv_done),
        .pop_i    (pop),
        .wr_dat_i (recv_data),
        .rd_dat_o (head_dat),
        .count_o  (fifo_count),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        send_en_d   = 1'b0;
        send_data_d = send_data_q;
        overflow_d  = overflow_q | drop;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    send_data_d = head_dat;
                    send_en_d   = 1'b1;
                    timer_d     = '0;
                    state_d     = ST_WAIT_RISE;
                end
            end
            ST_WAIT_RISE: begin
                // A missed busy rise is treated as a completed send; no retry.
                if (tx_busy)             state_d = ST_WAIT_FALL;
                else if (timer_q == TMR_MAX) state_d = ST_IDLE;
                else                     timer_d = timer_q + 1'b1;
            end
            ST_WAIT_FALL: begin
                if (!tx_busy) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            send_en_q   <= 1'b0;
            send_data_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            send_en_q   <= send_en_d;
            send_data_q <= send_data_d;
            overflow_q  <= overflow_d;
        end
    end

    assign send_en   = send_en_q;
    assign send_data = send_data_q;
    assign overflow  = overflow_q;

`ifdef UART_FIFO_STATS_EN
    logic [15:0] drop_cnt_q, timeout_cnt_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            drop_cnt_q    <= '0;
            timeout_cnt_q <= '0;
        end else begin
            if (drop && drop_cnt_q != 16'hFFFF)           drop_cnt_q    <= drop_cnt_q + 1'b1;
            if (timeout_hit && timeout_cnt_q != 16'hFFFF) timeout_cnt_q <= timeout_cnt_q + 1'b1;
        end
    end

    assign drop_cnt    = drop_cnt_q;
    assign timeout_cnt = timeout_cnt_q;
`endif

endmodule

// File: tb/tb_uart_word_fifo.sv
// Directed bench for uart_word_fifo: single word, burst, overflow, full push+pop, timeout, reset.
// Stats ports are connected and checked when UART_FIFO_STATS_EN is defined.
module tb_uart_word_fifo;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        recv_done = 1'b0;
    logic [63:0] recv_data = '0;
    logic        tx_busy = 1'b0;
    logic        send_en;
    logic [63:0] send_data;
    logic [3:0]  fifo_count;
    logic        overflow;
`ifdef UART_FIFO_STATS_EN
    logic [15:0] drop_cnt, timeout_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int n_sends = 0;

    uart_word_fifo dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .recv_done  (recv_done),
        .recv_data  (recv_data),
        .tx_busy    (tx_busy),
        .send_en    (send_en),
        .send_data  (send_data),
        .fifo_count (fifo_count),
        .overflow   (overflow)
`ifdef UART_FIFO_STATS_EN
        ,
        .drop_cnt    (drop_cnt),
        .timeout_cnt (timeout_cnt)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) if (send_en === 1'b1) n_sends++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at 1 ms, required to finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic push(input logic [63:0] w);
        recv_done = 1'b1;
        recv_data = w;
        tick();
        recv_done = 1'b0;
    endtask

    // Lower busy, wait for the next send_en, check the word, then acknowledge with a busy pulse.
    task automatic send_one(input string tag, input logic [63:0] exp);
        bit seen = 0;
        tx_busy = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (send_en) seen = 1;
        end
        chk({tag, "_seen"}, 64'(seen), 64'd1);
        chk({tag, "_data"}, send_data, exp);
        tx_busy = 1'b1;
        tick();
        tick();
    endtask

    task automatic settle();
        tx_busy = 1'b0;
        repeat (3) tick();
    endtask

    int base;
    int gap;

    initial begin
        tick();
        tick();
        chk("rst_count", 64'(fifo_count), 64'd0);
        chk("rst_send_en", 64'(send_en), 64'd0);
        chk("rst_send_data", send_data, 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        sys_rst = 1'b0;
        tick();

        // Single word: send_en two cycles after the recv_done cycle.
        push(64'h0123_4567_89AB_CDEF);
        chk("one_cnt1", 64'(fifo_count), 64'd1);
        chk("one_en_early", 64'(send_en), 64'd0);
        tick();
        chk("one_en", 64'(send_en), 64'd1);
        chk("one_data", send_data, 64'h0123_4567_89AB_CDEF);
        chk("one_cnt0", 64'(fifo_count), 64'd0);
        tx_busy = 1'b1;
        tick();
        chk("one_en_pulse", 64'(send_en), 64'd0);
        tick();
        settle();

        // Burst of 8 while busy, then drained in order.
        tx_busy = 1'b1;
        base = n_sends;
        for (int i = 1; i <= 8; i++) push(64'(i));
        tick();
        chk("burst_cnt", 64'(fifo_count), 64'd8);
        chk("burst_nosend", 64'(n_sends - base), 64'd0);
        for (int i = 1; i <= 8; i++) send_one($sformatf("burst%0d", i), 64'(i));
        settle();
        chk("burst_ovf", 64'(overflow), 64'd0);
        chk("burst_cnt0", 64'(fifo_count), 64'd0);

        // Overflow: ninth word dropped.
        tx_busy = 1'b1;
        for (int i = 1; i <= 9; i++) push(64'h100 + 64'(i));
        chk("ovf_cnt", 64'(fifo_count), 64'd8);
        chk("ovf_flag", 64'(overflow), 64'd1);
`ifdef UART_FIFO_STATS_EN
        chk("ovf_drop_cnt", 64'(drop_cnt), 64'd1);
`endif
        for (int i = 1; i <= 8; i++) send_one($sformatf("ovf%0d", i), 64'h100 + 64'(i));
        settle();
        chk("ovf_cnt0", 64'(fifo_count), 64'd0);
        chk("ovf_sticky", 64'(overflow), 64'd1);

        // Full FIFO with push in the pop cycle.
        tx_busy = 1'b1;
        for (int i = 1; i <= 8; i++) push(64'h200 + 64'(i));
        tx_busy = 1'b0;
        push(64'h209);
        chk("pp_en", 64'(send_en), 64'd1);
        chk("pp_data", send_data, 64'h201);
        chk("pp_cnt", 64'(fifo_count), 64'd8);
`ifdef UART_FIFO_STATS_EN
        chk("pp_drop_cnt", 64'(drop_cnt), 64'd1);
`endif
        tx_busy = 1'b1;
        tick();
        tick();
        for (int i = 2; i <= 9; i++) send_one($sformatf("pp%0d", i), 64'h200 + 64'(i));
        settle();

        // Timeout: busy never rises; next word follows after BUSY_TIMEOUT+2 cycles.
        push(64'h300);
        push(64'h301);
        chk("to_en", 64'(send_en), 64'd1);
        chk("to_data0", send_data, 64'h300);
        gap = 0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            gap++;
            if (send_en) break;
        end
        chk("to_gap", 64'(gap), 64'd1025);
        chk("to_data1", send_data, 64'h301);
        tx_busy = 1'b1;
        tick();
        tick();
        settle();
`ifdef UART_FIFO_STATS_EN
        chk("to_cnt", 64'(timeout_cnt), 64'd1);
`endif

        // Reset while in WAIT_FALL with three words queued.
        tx_busy = 1'b1;
        for (int i = 1; i <= 4; i++) push(64'h400 + 64'(i));
        tx_busy = 1'b0;
        tick();
        chk("rm_en", 64'(send_en), 64'd1);
        tx_busy = 1'b1;
        tick();
        chk("rm_cnt3", 64'(fifo_count), 64'd3);
        chk("rm_ovf_before", 64'(overflow), 64'd1);
        sys_rst = 1'b1;
        tick();
        chk("rm_cnt", 64'(fifo_count), 64'd0);
        chk("rm_send_en", 64'(send_en), 64'd0);
        chk("rm_send_data", send_data, 64'd0);
        chk("rm_ovf", 64'(overflow), 64'd0);
`ifdef UART_FIFO_STATS_EN
        chk("rm_drop_cnt", 64'(drop_cnt), 64'd0);
        chk("rm_to_cnt", 64'(timeout_cnt), 64'd0);
`endif
        sys_rst = 1'b0;
        tx_busy = 1'b0;
        base = n_sends;
        repeat (5) tick();
        chk("rm_nosend", 64'(n_sends - base), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
